// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its environment: hazard/redirect
// controls, the instruction-memory write port, and the registered IF/ID outputs.
interface if_stage_if #(
    parameter int AW = 6
);
    logic          freeze;
    logic          branch_taken;
    logic [31:0]   branch_addr;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   pc_out;
    logic [31:0]   instruction;
    logic          valid;
    logic [31:0]   pc;
    logic [31:0]   fetch_count;

    // Environment side: drives controls and the loader port, observes IF/ID.
    modport master (
        output freeze, branch_taken, branch_addr,
        output imem_we, imem_waddr, imem_wdata,
        input  pc_out, instruction, valid, pc, fetch_count
    );

    // Fetch-stage side.
    modport slave (
        input  freeze, branch_taken, branch_addr,
        input  imem_we, imem_waddr, imem_wdata,
        output pc_out, instruction, valid, pc, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// ARM instruction-fetch stage with internal instruction memory and IF/ID register.
// Branch redirects flush IF/ID to a bubble; hazard freezes hold PC and IF/ID.
module if_stage #(
    parameter int IMEM_DEPTH = 64,
    parameter int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    if_stage_if.slave bus
);
    logic [31:0]   mem_r [IMEM_DEPTH];

    logic [31:0]   pc_r;
    logic [31:0]   pc_out_r;
    logic [31:0]   instr_r;
    logic          valid_r;
    logic [31:0]   fetch_count_r;

    logic [AW-1:0] fetch_idx_s;
    logic [31:0]   fetch_word_s;
    logic [31:0]   pc_plus4_s;
    logic [31:0]   pc_nxt_s;
    logic [31:0]   pc_out_nxt_s;
    logic [31:0]   instr_nxt_s;
    logic          valid_nxt_s;
    logic [31:0]   fetch_count_nxt_s;

    // Byte offset bits and bits above the memory span are ignored, so the
    // fetch index wraps modulo the memory depth.
    assign fetch_idx_s  = pc_r[AW+1:2];
    assign fetch_word_s = mem_r[fetch_idx_s];
    assign pc_plus4_s   = pc_r + 32'd4;

    // Loader write port; contents survive reset and ignore stage controls.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem_r[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // Next-state selection: redirect beats freeze, freeze beats sequential fetch.
    always_comb begin
        pc_nxt_s          = pc_r;
        pc_out_nxt_s      = pc_out_r;
        instr_nxt_s       = instr_r;
        valid_nxt_s       = valid_r;
        fetch_count_nxt_s = fetch_count_r;
        if (bus.branch_taken) begin
            pc_nxt_s     = bus.branch_addr;
            pc_out_nxt_s = 32'd0;
            instr_nxt_s  = 32'd0;
            valid_nxt_s  = 1'b0;
        end else if (bus.freeze) begin
            pc_nxt_s     = pc_r;
            pc_out_nxt_s = pc_out_r;
            instr_nxt_s  = instr_r;
            valid_nxt_s  = valid_r;
        end else begin
            pc_nxt_s          = pc_plus4_s;
            pc_out_nxt_s      = pc_plus4_s;
            instr_nxt_s       = fetch_word_s;
            valid_nxt_s       = 1'b1;
            fetch_count_nxt_s = fetch_count_r + 32'd1;
        end
    end

    // PC and IF/ID register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= 32'd0;
            pc_out_r      <= 32'd0;
            instr_r       <= 32'd0;
            valid_r       <= 1'b0;
            fetch_count_r <= 32'd0;
        end else begin
            pc_r          <= pc_nxt_s;
            pc_out_r      <= pc_out_nxt_s;
            instr_r       <= instr_nxt_s;
            valid_r       <= valid_nxt_s;
            fetch_count_r <= fetch_count_nxt_s;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.pc_out      = pc_out_r;
    assign bus.instruction = instr_r;
    assign bus.valid       = valid_r;
    assign bus.fetch_count = fetch_count_r;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized
// freeze/branch/write traffic, compared against a behavioural fetch model.
module tb_if_stage;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_pc_out, m_instr, m_cnt;
    logic        m_valid;

    if_stage_if #(.AW(AW)) bus();

    if_stage #(.IMEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    bus.pc,                 m_pc);
        check({tag, ".pcout"}, bus.pc_out,             m_pc_out);
        check({tag, ".instr"}, bus.instruction,        m_instr);
        check({tag, ".valid"}, {31'd0, bus.valid},     {31'd0, m_valid});
        check({tag, ".count"}, bus.fetch_count,        m_cnt);
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_pc_out = 32'd0; m_instr = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
    endtask

    // One clock edge: the model applies the stage rules to the current inputs.
    task automatic step(input string tag);
        logic [31:0] idx;
        idx = (m_pc >> 2) % DEPTH;
        if (rst) begin
            model_reset();
        end else if (bus.branch_taken) begin
            m_pc = bus.branch_addr; m_pc_out = 32'd0; m_instr = 32'd0; m_valid = 1'b0;
        end else if (!bus.freeze) begin
            m_instr = m_mem[idx]; m_pc_out = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        if (bus.imem_we) m_mem[bus.imem_waddr] = bus.imem_wdata;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_ctl(input logic frz, input logic br, input logic [31:0] addr);
        bus.freeze = frz; bus.branch_taken = br; bus.branch_addr = addr;
    endtask

    task automatic async_reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] seed_words [4];
        seed_words[0] = 32'hE3A00014; seed_words[1] = 32'hE3A01A01;
        seed_words[2] = 32'hE3A01A01; seed_words[3] = 32'hE0B04000;

        set_ctl(1'b0, 1'b0, 32'd0);
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = 32'd0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hxxxxxxxx;
        #1;
        check_all("reset");

        // Preload memory while held in reset.
        for (int i = 0; i < DEPTH; i++) begin
            bus.imem_we    = 1'b1;
            bus.imem_waddr = AW'(i);
            if (i < 4)        bus.imem_wdata = seed_words[i];
            else if (i == 8)  bus.imem_wdata = 32'hE3A02005;
            else              bus.imem_wdata = $urandom();
            step("load");
        end
        bus.imem_we = 1'b0;
        rst = 1'b0;

        // Sequential fetch, then a two-edge freeze after edge 2.
        step("seq1");
        check("seq1.lit", bus.instruction, 32'hE3A00014);
        check("seq1.pc4", bus.pc_out, 32'd4);
        step("seq2");
        set_ctl(1'b1, 1'b0, 32'd0);
        step("frz1");
        step("frz2");
        check("frz.lit", bus.instruction, 32'hE3A01A01);
        check("frz.cnt", bus.fetch_count, 32'd2);
        set_ctl(1'b0, 1'b0, 32'd0);
        step("seq3");
        check("seq3.pc", bus.pc_out, 32'd12);
        step("seq4");
        check("seq4.lit", bus.instruction, 32'hE0B04000);

        // Branch alone, then branch with freeze, to 0x20.
        set_ctl(1'b0, 1'b1, 32'h20);
        step("br");
        check("br.pc", bus.pc, 32'h20);
        set_ctl(1'b0, 1'b0, 32'd0);
        step("br.tgt");
        check("br.lit", bus.instruction, 32'hE3A02005);
        check("br.pc4", bus.pc_out, 32'h24);
        set_ctl(1'b1, 1'b1, 32'h20);
        step("brfz");
        set_ctl(1'b0, 1'b0, 32'd0);
        step("brfz.tgt");

        // Memory wrap and 32-bit PC wrap.
        set_ctl(1'b0, 1'b1, 32'hFC);
        step("wrap.br");
        set_ctl(1'b0, 1'b0, 32'd0);
        step("wrap63");
        step("wrap0");
        check("wrap0.pc4", bus.pc_out, 32'h104);
        set_ctl(1'b0, 1'b1, 32'hFFFFFFFC);
        step("pcwrap.br");
        set_ctl(1'b0, 1'b0, 32'd0);
        step("pcwrap");
        check("pcwrap.pc", bus.pc, 32'd0);

        // Async reset between edges, then restart at word 0 with memory intact.
        async_reset_pulse("arst");
        step("arst.re1");
        check("arst.lit", bus.instruction, 32'hE3A00014);
        step("arst.re2");

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            int r;
            r = $urandom_range(0, 99);
            bus.freeze       = ($urandom_range(0, 99) < 25);
            bus.branch_taken = (r < 10);
            bus.branch_addr  = (r < 5) ? (32'($urandom_range(0, 127)) << 2) : $urandom();
            bus.imem_we      = ($urandom_range(0, 99) < 30);
            bus.imem_waddr   = AW'($urandom_range(0, DEPTH - 1));
            bus.imem_wdata   = $urandom();
            if ($urandom_range(0, 99) < 2) begin
                async_reset_pulse("rnd.arst");
            end
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the ARM pipeline, with its IF/ID pipeline register. It keeps the program counter and an internal word-addressed instruction memory that the bench or loader writes. Each cycle it presents the fetched instruction and PC+4 to the decode stage through a registered interface. It honours hazard freezes and branch redirects from the execute stage by holding or inserting a bubble.

## Interface
- IMEM_DEPTH, 64: instruction memory depth in 32-bit words; a power of two, at least 2.
- AW, log2(IMEM_DEPTH): word-index width, derived from IMEM_DEPTH.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  hazard stall; holds the PC and the IF/ID register
- branch_taken  in  1  redirect from EXE; also flushes the IF/ID register
- branch_addr  in  32  byte address of the redirect target
- imem_we  in  1  instruction memory write enable
- imem_waddr  in  AW  word index to write
- imem_wdata  in  32  word to write
- pc_out  out  32  registered PC+4 of the fetched instruction; feeds decode PCIn
- instruction  out  32  registered instruction; feeds decode instructionReg
- valid  out  1  1 when the IF/ID register holds a real instruction, 0 when it holds a bubble
- pc  out  32  current fetch PC (debug)
- fetch_count  out  32  number of instructions loaded into IF/ID since reset

## Operation
- Fetch index is pc[AW+1:2]. pc[1:0] is ignored. Higher bits are ignored, so the index wraps modulo IMEM_DEPTH.
- Memory read is combinational.
- Memory write is synchronous on the clk edge when imem_we=1.
- A same-cycle read and write of the same word reads the old data.
- Memory contents are not affected by rst.
- PC update at each edge, in priority order:
  1. rst: pc=0.
  2. branch_taken=1: pc=branch_addr.
  3. freeze=1: pc holds.
  4. Otherwise: pc=pc+4, 32-bit and wrapping at 2^32.
- IF/ID register update at each edge, same priority:
  1. rst: all fields 0.
  2. branch_taken=1: bubble, meaning instruction=0, pc_out=0, valid=0.
  3. freeze=1: hold all fields.
  4. Otherwise: instruction=imem[index], pc_out=pc+4, valid=1.
- fetch_count increments by 1, wrapping, exactly at edges that load valid=1.
- branch_taken wins over freeze when both are high.
- Memory writes are independent of freeze and branch_taken.

## Timing
- Reset values: pc=0, pc_out=0, instruction=0, valid=0, fetch_count=0.
- Asserting rst clears all outputs immediately, with no clock needed, including mid-stream.
- After rst deasserts, the first rising edge loads imem[0] with pc_out=4. This gives 1-cycle fetch latency.
- Branch: branch_taken sampled high at edge N produces a bubble at N and pc=branch_addr. imem[branch_addr>>2] appears at edge N+1 with pc_out=branch_addr+4.
- Freeze: freeze high for k edges holds all outputs and pc for those k edges. Fetching resumes at the first edge with freeze=0.

## Test plan
- Sequential fetch: preload imem[0..3] with E3A00014, E3A01A01, E3A01A01, E0B04000. Release rst. Edges 1–4 give instruction equal to those words, pc_out=4/8/12/16, valid=1, fetch_count=4.
- Freeze: after edge 2, hold freeze=1 for 2 edges. instruction stays E3A01A01, pc_out stays 8, pc stays 8, fetch_count stays 2. Edge 5 gives E3A01A01 (word 2) with pc_out=12.
- Branch: preload imem[8]=E3A02005, then branch_taken=1 with branch_addr=0x20 for one edge. That edge gives valid=0, instruction=0, pc_out=0, pc=0x20, fetch_count unchanged. The next edge gives E3A02005 with pc_out=0x24.
- Branch plus freeze: both high on one edge. Result is identical to the branch-only case, and pc=branch_addr.
- Wrap: IMEM_DEPTH=64, branch to 0xFC. The next edge gives imem[63] with pc_out=0x100. The following edge gives imem[0] with pc_out=0x104.
- Async reset mid-stream: pulse rst for 3 ns between edges. All outputs read 0 before the next edge. After release, fetching restarts at imem[0] and memory contents are intact.
